// File: rtl/mini_cpu_core.sv
// mini_cpu_core: multi-cycle fetch/exec/mem core with handshaked instruction and data ports
module mini_cpu_core #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int NREG = 8,
  localparam int RW = $clog2(NREG),
  localparam int IW = 4 + 2 * RW + DW
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          START,
  output logic          IMEM_REQ,
  output logic [AW-1:0] IMEM_ADDR,
  input  logic          IMEM_ACK,
  input  logic [IW-1:0] IMEM_DATA,
  output logic          DMEM_REQ,
  output logic          DMEM_WE,
  output logic [AW-1:0] DMEM_ADDR,
  output logic [DW-1:0] DMEM_WDATA,
  input  logic          DMEM_ACK,
  input  logic [DW-1:0] DMEM_RDATA,
  output logic [AW-1:0] PC,
  output logic          ZERO,
  output logic          HALTED
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, MEM} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ir;
  logic [AW-1:0] pc, pc_inc;
  logic [DW-1:0] rf [NREG];
  logic zero, halted;
  logic [3:0] op;
  logic [RW-1:0] rd, rs1, rs2;
  logic [DW-1:0] imm, rdv, rs1v, rs2v, alu;
  logic is_alu, is_mem, is_st, taken;
  assign op = ir[IW-1 -: 4];
  assign rd = ir[IW-5 -: RW];
  assign rs1 = ir[IW-5-RW -: RW];
  assign imm = ir[DW-1:0];
  assign rs2 = imm[RW-1:0];
  assign rdv = rf[rd];
  assign rs1v = rf[rs1];
  assign rs2v = rf[rs2];
  assign pc_inc = pc + 1'b1;
  assign is_alu = op <= 4'h6;
  assign is_st = op == 4'h8;
  assign is_mem = op == 4'h7 || is_st;
  assign taken = (op == 4'h9 && rs1v == '0) || op == 4'hA;
  always_comb
    alu = op == 4'h0 ? imm :
          op == 4'h1 ? rs2v :
          op == 4'h2 ? rs1v + rs2v :
          op == 4'h3 ? rs1v - rs2v :
          op == 4'h4 ? rs1v & rs2v :
          op == 4'h5 ? rs1v | rs2v : rs1v >> rs2v;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = START ? FETCH : IDLE;
      FETCH: state_nx = IMEM_ACK ? EXEC : FETCH;
      EXEC:  state_nx = is_mem ? MEM : op == 4'hF ? IDLE : FETCH;
      MEM:   state_nx = DMEM_ACK ? FETCH : MEM;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      pc <= '0;
      ir <= '0;
      zero <= 1'b0;
      halted <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (state == IDLE && START) halted <= 1'b0;
      if (state == FETCH && IMEM_ACK) ir <= IMEM_DATA;
      if (state == EXEC) begin
        if (is_alu) begin
          rf[rd] <= alu;
          zero <= alu == '0;
        end
        pc <= taken ? imm[AW-1:0] : is_mem ? pc : pc_inc;
        if (op == 4'hF) halted <= 1'b1;
      end
      if (state == MEM && DMEM_ACK) begin
        pc <= pc_inc;
        if (!is_st) begin
          rf[rd] <= DMEM_RDATA;
          zero <= DMEM_RDATA == '0;
        end
      end
    end
  // requests decode straight from state so an async reset drops them at once
  assign IMEM_REQ = state == FETCH;
  assign IMEM_ADDR = pc;
  assign DMEM_REQ = state == MEM;
  assign DMEM_WE = DMEM_REQ && is_st;
  assign DMEM_ADDR = DMEM_REQ ? rs1v[AW-1:0] : '0;
  assign DMEM_WDATA = DMEM_WE ? rdv : '0;
  assign PC = pc;
  assign ZERO = zero;
  assign HALTED = halted;
endmodule

// File: tb/tb_mini_cpu_core.sv
// tb_mini_cpu_core: directed program runs on default and wide configurations with a store scoreboard
module tb_mini_cpu_core;
  logic clk = 0, rst_n, start, imem_ack, dmem_ack;
  logic [27:0] imem_data;
  logic [15:0] dmem_rdata;
  int sel = 0, checks = 0, errs = 0, cyc = 0;
  logic req0, dreq0, dwe0, zero0, halt0, req1, dreq1, dwe1, zero1, halt1;
  logic [7:0] addr0, daddr0, dwd0, pc0;
  logic [11:0] addr1, daddr1, pc1;
  logic [15:0] dwd1;
  logic imem_req, dmem_req, dmem_we, zero, halted;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, pc;
  typedef struct {logic we; logic [31:0] addr, wdata;} ex_t;
  ex_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mini_cpu_core dut0 (
    .CLK(clk), .RESET_N(rst_n), .START(start && sel == 0),
    .IMEM_REQ(req0), .IMEM_ADDR(addr0), .IMEM_ACK(imem_ack && sel == 0), .IMEM_DATA(imem_data[17:0]),
    .DMEM_REQ(dreq0), .DMEM_WE(dwe0), .DMEM_ADDR(daddr0), .DMEM_WDATA(dwd0),
    .DMEM_ACK(dmem_ack && sel == 0), .DMEM_RDATA(dmem_rdata[7:0]),
    .PC(pc0), .ZERO(zero0), .HALTED(halt0));

  mini_cpu_core #(.DW(16), .AW(12), .NREG(16)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .START(start && sel == 1),
    .IMEM_REQ(req1), .IMEM_ADDR(addr1), .IMEM_ACK(imem_ack && sel == 1), .IMEM_DATA(imem_data),
    .DMEM_REQ(dreq1), .DMEM_WE(dwe1), .DMEM_ADDR(daddr1), .DMEM_WDATA(dwd1),
    .DMEM_ACK(dmem_ack && sel == 1), .DMEM_RDATA(dmem_rdata),
    .PC(pc1), .ZERO(zero1), .HALTED(halt1));

  assign imem_req = sel == 1 ? req1 : req0;
  assign dmem_req = sel == 1 ? dreq1 : dreq0;
  assign dmem_we = sel == 1 ? dwe1 : dwe0;
  assign zero = sel == 1 ? zero1 : zero0;
  assign halted = sel == 1 ? halt1 : halt0;
  assign imem_addr = sel == 1 ? 32'(addr1) : 32'(addr0);
  assign dmem_addr = sel == 1 ? 32'(daddr1) : 32'(daddr0);
  assign dmem_wdata = sel == 1 ? 32'(dwd1) : 32'(dwd0);
  assign pc = sel == 1 ? 32'(pc1) : 32'(pc0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] enc(input logic [3:0] op, input int rd, input int rs1, input logic [15:0] imm);
    return sel == 1 ? {op, 4'(rd), 4'(rs1), imm} : {10'd0, op, 3'(rd), 3'(rs1), imm[7:0]};
  endfunction

  task automatic expect_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    sb.push_back('{we, addr, wdata});
  endtask

  task automatic go();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic fetch(input logic [3:0] op, input int rd, input int rs1, input logic [15:0] imm,
                       input logic [31:0] exp_addr, input int waits);
    int n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("imem_req", 32'(imem_req), 1);
    for (int i = 0; i < waits; i++) begin
      chk("imem_addr_hold", imem_addr, exp_addr);
      @(negedge clk);
      chk("imem_req_hold", 32'(imem_req), 1);
    end
    chk("imem_addr", imem_addr, exp_addr);
    imem_data = enc(op, rd, rs1, imm);
    imem_ack = 1;
    @(negedge clk);
    imem_ack = 0;
  endtask

  task automatic mem(input int waits, input logic [15:0] rdata);
    int n = 0;
    ex_t e = '{1'b0, 32'd0, 32'd0};
    while (!dmem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("sb_nonempty", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) e = sb.pop_front();
    for (int i = 0; i <= waits; i++) begin
      chk("dmem_req", 32'(dmem_req), 1);
      chk("dmem_we", 32'(dmem_we), 32'(e.we));
      chk("dmem_addr", dmem_addr, e.addr);
      chk("dmem_wdata", dmem_wdata, e.wdata);
      if (i < waits) @(negedge clk);
    end
    dmem_rdata = rdata;
    dmem_ack = 1;
    @(negedge clk);
    dmem_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int t0;
    logic [15:0] amax;
    rst_n = 0; start = 0; imem_ack = 0; dmem_ack = 0; imem_data = '0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_dmem_req", 32'(dmem_req), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_zero", 32'(zero), 0);
    rst_n = 1;
    imem_ack = 1;
    repeat (2) @(negedge clk);
    imem_ack = 0;
    chk("idle_no_req", 32'(imem_req), 0);
    chk("idle_pc", pc, 0);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      amax = s == 1 ? 16'h0FFF : 16'h00FF;
      go();
      t0 = cyc;
      fetch(4'h0, 1, 0, 16'h05, 0, 0);
      fetch(4'h0, 2, 0, 16'h03, 1, 0);
      fetch(4'h2, 3, 1, 16'h02, 2, 0);
      fetch(4'hF, 0, 0, 16'h00, 3, 0);
      @(negedge clk);
      chk("a_halted", 32'(halted), 1);
      chk("a_pc", pc, 4);
      chk("a_cycles", 32'(cyc - t0), 8);
      chk("a_zero", 32'(zero), 0);
      go();
      chk("a_halt_clr", 32'(halted), 0);
      expect_mem(1, 5, 8);
      fetch(4'h8, 3, 1, 16'h00, 4, 0);
      mem(0, 0);
      fetch(4'hA, 0, 0, amax, 5, 0);
      fetch(4'hB, 0, 0, 16'h00, 32'(amax), 1);
      fetch(4'hF, 0, 0, 16'h00, 0, 0);
      @(negedge clk);
      chk("a_wrap_pc", pc, 1);
    end
    sel = 0;
    go();
    fetch(4'h3, 4, 1, 16'h01, 1, 0);
    @(negedge clk);
    chk("sub_zero", 32'(zero), 1);
    fetch(4'h3, 5, 2, 16'h01, 2, 0);
    @(negedge clk);
    chk("sub_nz", 32'(zero), 0);
    expect_mem(1, 5, 8'hFE);
    fetch(4'h8, 5, 1, 16'h00, 3, 0);
    mem(0, 0);
    expect_mem(1, 3, 0);
    fetch(4'h8, 4, 2, 16'h00, 4, 1);
    mem(1, 0);
    expect_mem(1, 3, 5);
    fetch(4'h8, 1, 2, 16'h00, 5, 0);
    mem(3, 0);
    expect_mem(0, 3, 0);
    fetch(4'h7, 6, 2, 16'h00, 6, 0);
    mem(2, 16'h5A);
    chk("ld_zero", 32'(zero), 0);
    expect_mem(1, 5, 8'h5A);
    fetch(4'h8, 6, 1, 16'h00, 7, 0);
    mem(0, 0);
    fetch(4'h9, 0, 1, 16'h40, 8, 0);
    fetch(4'h9, 0, 0, 16'h10, 9, 0);
    fetch(4'h0, 7, 0, 16'h09, 32'h10, 0);
    fetch(4'h6, 6, 6, 16'h07, 32'h11, 0);
    @(negedge clk);
    chk("srl_zero", 32'(zero), 1);
    expect_mem(1, 5, 0);
    fetch(4'h8, 6, 1, 16'h00, 32'h12, 0);
    mem(0, 0);
    fetch(4'h2, 2, 2, 16'h02, 32'h13, 0);
    expect_mem(1, 5, 6);
    fetch(4'h8, 2, 1, 16'h00, 32'h14, 0);
    mem(0, 0);
    fetch(4'h7, 1, 2, 16'h00, 32'h15, 0);
    @(negedge clk);
    chk("mem_req_pre_rst", 32'(dmem_req), 1);
    #2 rst_n = 0;
    #1;
    chk("rst_dmem_drop", 32'(dmem_req), 0);
    chk("rst_mid_pc", pc, 0);
    chk("rst_mid_imem", 32'(imem_req), 0);
    dmem_rdata = 16'hAA;
    dmem_ack = 1;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    dmem_ack = 0;
    chk("post_rst_idle", 32'(imem_req), 0);
    chk("post_rst_dreq", 32'(dmem_req), 0);
    chk("idle_we_zero", 32'(dmem_we), 0);
    chk("idle_addr_zero", dmem_addr, 0);
    chk("idle_wdata_zero", dmem_wdata, 0);
    chk("post_rst_pc", pc, 0);
    go();
    expect_mem(1, 0, 0);
    fetch(4'h8, 1, 2, 16'h00, 0, 0);
    mem(0, 0);
    fetch(4'hF, 0, 0, 16'h00, 1, 0);
    @(negedge clk);
    chk("final_pc", pc, 2);
    chk("final_halted", 32'(halted), 1);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule

// File: doc/mini_cpu_core.md
MINI_CPU_CORE -- requirements
Module: mini_cpu_core

Interface
REQ-001 Parameter DW, default 8: data/register width, 4..32.
REQ-002 Parameter AW, default 8: PC and memory address width, AW<=DW.
REQ-003 Parameter NREG, default 8: register count, power of two >=2; RW=log2(NREG); instruction width IW=4+2*RW+DW.
REQ-004 Ports; reset is asynchronous, active-low:
- CLK  in  1  rising-edge clock
- RESET_N  in  1  async active-low reset
- START  in  1  leave IDLE, begin fetching at PC
- IMEM_REQ  out  1  instruction fetch request
- IMEM_ADDR  out  AW  fetch address, equal to PC
- IMEM_ACK  in  1  fetch complete this cycle
- IMEM_DATA  in  IW  instruction, valid with IMEM_ACK
- DMEM_REQ  out  1  data access request
- DMEM_WE  out  1  1=store, 0=load, valid with DMEM_REQ
- DMEM_ADDR  out  AW  data address
- DMEM_WDATA  out  DW  store data
- DMEM_ACK  in  1  data access complete this cycle
- DMEM_RDATA  in  DW  load data, valid with DMEM_ACK
- PC  out  AW  program counter
- ZERO  out  1  last ALU result was zero
- HALTED  out  1  HALT executed, core idle

Function
REQ-005 Instruction fields: OP=[IW-1:IW-4], RD=next RW bits, RS1=next RW bits, IMM=[DW-1:0]; RS2=IMM[RW-1:0].
REQ-006 Opcodes: 0 LDI rd<=IMM; 1 MOV rd<=rs2; 2 ADD rd<=rs1+rs2; 3 SUB rd<=rs1-rs2; 4 AND; 5 OR; 6 SRL rd<=rs1>>rs2; 7 LD rd<=mem[rs1]; 8 ST mem[rs1]<=rd; 9 BEQZ if rs1==0 PC<=IMM[AW-1:0]; A JMP PC<=IMM[AW-1:0]; F HALT; B-E NOP.
REQ-007 Arithmetic modulo 2^DW, carry/borrow discarded; SRL logical, shift amount = full rs2 value, any amount >=DW yields 0.
REQ-008 Memory addresses use rs1[AW-1:0]; PC increments by 1 modulo 2^AW (0xFF wraps to 0x00 at AW=8).
REQ-009 States IDLE, FETCH, EXEC, MEM; reset enters IDLE.
REQ-010 IDLE: all requests low; START=1 -> FETCH next cycle, HALTED cleared same edge.
REQ-011 FETCH: IMEM_REQ=1, IMEM_ADDR=PC held stable until IMEM_ACK; on ACK latch IMEM_DATA -> EXEC; ACK may arrive the first request cycle.
REQ-012 EXEC (one cycle): ALU/LDI/MOV write rd and update ZERO, PC+1 -> FETCH; BEQZ/JMP set PC (taken) or PC+1 -> FETCH, ZERO unchanged; NOP PC+1 -> FETCH; LD/ST -> MEM; HALT PC+1, HALTED=1 -> IDLE.
REQ-013 MEM: DMEM_REQ=1, DMEM_WE/ADDR/WDATA held stable until DMEM_ACK; on ACK: LD writes rd from DMEM_RDATA and updates ZERO, PC+1 -> FETCH.
REQ-014 Minimum latency: 2 cycles per non-memory instruction, 3 per LD/ST, each extended by ACK wait cycles.
REQ-015 ACK inputs outside FETCH/MEM ignored; START outside IDLE ignored.
REQ-016 Register file is written only in EXEC or MEM-ACK cycles; rd==rs1 reads the pre-write value.
REQ-017 DMEM_WE, DMEM_ADDR, DMEM_WDATA are 0 when DMEM_REQ=0.

Reset
REQ-018 RESET_N low asynchronously forces IDLE, PC=0, all registers=0, ZERO=0, HALTED=0, IMEM_REQ=0, DMEM_REQ=0, regardless of state.
REQ-019 Reset during FETCH or MEM abandons the transaction with no register, PC or memory-side effect; REQ drops immediately (not at next edge).
REQ-020 After RESET_N rises, the core stays in IDLE until START.

Verification
REQ-021 Reset, START, IMEM ACK same cycle: LDI r1,0x05; LDI r2,0x03; ADD r3,r1,r2; HALT -> r3=0x08, PC=4, HALTED=1, 8 cycles from first request.
REQ-022 SUB r4,r1,r1 with r1=0x05 -> r4=0x00, ZERO=1; SUB r5,r2,r1 (3-5) -> r5=0xFE, ZERO=0.
REQ-023 ST r1->[r2=0x03] with DMEM_ACK delayed 3 cycles: DMEM_REQ=1, WE=1, ADDR=0x03, WDATA=0x05 held 4 cycles; then LD r6,[r2] with RDATA=0x5A -> r6=0x5A.
REQ-024 BEQZ r0,0x10 with r0=0 -> next IMEM_ADDR=0x10; JMP 0xFF then NOP -> PC wraps to 0x00; SRL by 9 at DW=8 -> 0.
REQ-025 RESET_N low mid-MEM with DMEM_REQ=1 -> DMEM_REQ=0 immediately, PC=0, registers 0; late DMEM_ACK ignored.
REQ-026 Rerun REQ-021 at DW=16, AW=12, NREG=16: identical results, PC wraps at 0xFFF.
